// File: rtl/barrett_reduce_pipe.sv
// Three-stage streaming Barrett reducer: a (2K bits) -> a mod Q, with a pass-through tag.
// One global enable advances every stage, so a stalled output freezes the whole pipe.
module barrett_reduce_pipe #(
   parameter int Q     = 3347,
   parameter int TAG_W = 4,
   localparam int K    = $clog2(Q),
   localparam longint unsigned MU = (64'd1 << (2*K)) / Q
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*K-1:0]   in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     out_data,
   output logic [TAG_W-1:0] out_tag
);
   localparam int W = 2*K + 1;
   localparam logic [W-1:0]   MU_W = W'(MU);
   localparam logic [W-1:0]   Q_W  = W'(Q);
   localparam logic [K+1:0]   Q1   = (K+2)'(Q);
   localparam logic [K+1:0]   Q2   = (K+2)'(2*Q);
   localparam logic [K+1:0]   Q3   = (K+2)'(3*Q);

   logic             en;
   logic [2:0]       vld_pipe_q, vld_pipe_d;
   logic [2*K-1:0]   a1_q, a1_d;
   logic [W-1:0]     qh1_q, qh1_d;
   logic [K+1:0]     r2_q, r2_d;
   logic [K-1:0]     d3_q, d3_d;
   logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;

   always_comb begin
      en         = !vld_pipe_q[2] || out_ready;
      in_ready   = en;
      vld_pipe_d = vld_pipe_q;
      a1_d       = a1_q;
      qh1_d      = qh1_q;
      r2_d       = r2_q;
      d3_d       = d3_q;
      tag1_d     = tag1_q;
      tag2_d     = tag2_q;
      tag3_d     = tag3_q;
      if (en) begin
         vld_pipe_d = {vld_pipe_q[1:0], in_valid};
         // S1: quotient estimate numerator, fits in 2K+1 bits since MU < 2^(K+1)
         a1_d       = in_data;
         qh1_d      = W'(in_data >> K) * MU_W;
         tag1_d     = in_tag;
         // S2: remainder estimate lands in [0, 4Q), so K+2 bits are exact
         r2_d       = (K+2)'({1'b0, a1_q} - (qh1_q >> K) * Q_W);
         tag2_d     = tag1_q;
         if (r2_q >= Q3)      d3_d = K'(r2_q - Q3);
         else if (r2_q >= Q2) d3_d = K'(r2_q - Q2);
         else if (r2_q >= Q1) d3_d = K'(r2_q - Q1);
         else                 d3_d = K'(r2_q);
         tag3_d     = tag2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         a1_q       <= '0;
         qh1_q      <= '0;
         r2_q       <= '0;
         d3_q       <= '0;
         tag1_q     <= '0;
         tag2_q     <= '0;
         tag3_q     <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         a1_q       <= a1_d;
         qh1_q      <= qh1_d;
         r2_q       <= r2_d;
         d3_q       <= d3_d;
         tag1_q     <= tag1_d;
         tag2_q     <= tag2_d;
         tag3_q     <= tag3_d;
      end
   end

   assign out_valid = vld_pipe_q[2];
   assign out_data  = d3_q;
   assign out_tag   = tag3_q;
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Randomised bench for barrett_reduce_pipe at Q=3347, plus Q=7681 and Q=5 instances,
// checked against plain a % Q.
module tb_barrett_reduce_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [23:0] in_data = '0;
   logic [3:0]  in_tag = '0, out_tag;
   logic [11:0] out_data;

   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
   logic [25:0] b_in_data = '0;
   logic [3:0]  b_in_tag = '0, b_out_tag;
   logic [12:0] b_out_data;

   logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
   logic [5:0]  c_in_data = '0;
   logic [3:0]  c_in_tag = '0, c_out_tag;
   logic [2:0]  c_out_data;

   int checks = 0, failures = 0;

   typedef struct {
      longint     data;
      logic [3:0] tag;
      int         cyc;
   } beat_t;

   barrett_reduce_pipe #(.Q(3347), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

   barrett_reduce_pipe #(.Q(7681), .TAG_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_tag(b_in_tag), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag));

   barrett_reduce_pipe #(.Q(5), .TAG_W(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_tag(c_in_tag), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .out_data(c_out_data), .out_tag(c_out_tag));

   function automatic longint ref_mod(longint a, longint q);
      return a % q;
   endfunction

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b%b%b exp=000", out_valid, b_out_valid, c_out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      checks++;
      if (out_data !== 12'd0 || out_tag !== 4'd0) begin
         failures++; $display("FAIL reset_data got=%0d/%0d exp=0/0", out_data, out_tag);
      end
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [23:0] a_v [5] = '{24'd0, 24'd3346, 24'd3347, 24'd11195716, 24'd16777215};
      logic [11:0] e_v [5] = '{12'd0, 12'd3346, 12'd0, 12'd1, 12'd2051};
      int seen = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc < 5) begin
            in_valid = 1'b1; in_data = a_v[cyc]; in_tag = 4'(cyc + 1);
         end else in_valid = 1'b0;
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (seen >= 5 || cyc != seen + 3 || out_data !== e_v[seen] || out_tag !== 4'(seen + 1)) begin
               failures++;
               $display("FAIL directed beat=%0d cyc=%0d got=%0d tag=%0d exp=%0d tag=%0d at cyc %0d",
                        seen, cyc, out_data, out_tag, (seen < 5) ? e_v[seen] : 12'd0, seen + 1, seen + 3);
            end
            seen++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (seen != 5) begin failures++; $display("FAIL directed_count got=%0d exp=5", seen); end
   endtask

   task automatic test_backpressure();
      bit          pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      beat_t       exp_q [$];
      beat_t       e;
      int          sent = 0, got = 0;
      bit          acc = 1'b0, held = 1'b0;
      logic [11:0] hd = '0;
      logic [3:0]  ht = '0;
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         out_ready = pat[cyc % 8];
         if (acc || !in_valid) begin
            if (sent < 8) begin
               in_valid = 1'b1; in_data = 24'($urandom); in_tag = 4'($urandom);
            end else in_valid = 1'b0;
         end
         acc = 1'b0;
         @(negedge clk);
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            failures++;
            $display("FAIL bp_in_ready got=%b exp=%b", in_ready, !out_valid || out_ready);
         end
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
               failures++;
               $display("FAIL bp_hold got=%b/%0d/%0d exp=1/%0d/%0d", out_valid, out_data, out_tag, hd, ht);
            end
         end
         held = out_valid && !out_ready;
         hd = out_data; ht = out_tag;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL bp_extra got=%0d exp=none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== 12'(e.data) || out_tag !== e.tag) begin
                  failures++;
                  $display("FAIL bp_data got=%0d/%0d exp=%0d/%0d", out_data, out_tag, e.data, e.tag);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            e.data = ref_mod(longint'(in_data), 3347); e.tag = in_tag; e.cyc = cyc;
            exp_q.push_back(e); sent++; acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got); end
   endtask

   task automatic test_back_to_back();
      beat_t exp_q [$];
      beat_t e;
      int    sent = 0, got = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 120; cyc++) begin
         if (sent < 60 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            in_tag = 4'($urandom);
         end else in_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL b2b_extra got=%0d exp=none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== 12'(e.data) || out_tag !== e.tag || cyc != e.cyc + 3) begin
                  failures++;
                  $display("FAIL b2b_data got=%0d/%0d@%0d exp=%0d/%0d@%0d",
                           out_data, out_tag, cyc, e.data, e.tag, e.cyc + 3);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            e.data = ref_mod(longint'(in_data), 3347); e.tag = in_tag; e.cyc = cyc;
            exp_q.push_back(e); sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (got != sent || sent == 0) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got, sent); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 24'($urandom); in_tag = 4'(i + 9);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL mrst_pre got=%b exp=1", out_valid); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 12'd0 || out_tag !== 4'd0) begin
         failures++;
         $display("FAIL mrst_async got=%b/%b/%0d/%0d exp=0/1/0/0", out_valid, in_ready, out_data, out_tag);
      end
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_stale cyc=%0d got=1 exp=0", cyc); end
         @(posedge clk); #1;
      end
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_valid = (cyc == 0); in_data = 24'd6694; in_tag = 4'd7;
         @(negedge clk);
         checks++;
         if (out_valid !== (cyc == 3) || (cyc == 3 && (out_data !== 12'd0 || out_tag !== 4'd7))) begin
            failures++;
            $display("FAIL mrst_next cyc=%0d got=%b/%0d/%0d exp=%b/0/7", cyc, out_valid, out_data, out_tag, cyc == 3);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_param();
      longint bq [$];
      longint cq [$];
      longint e;
      int     bgot = 0, cgot = 0;
      for (int cyc = 0; cyc < 10010; cyc++) begin
         if (cyc < 10000) begin
            b_in_valid = 1'b1; c_in_valid = 1'b1;
            b_in_data = ($urandom_range(0, 31) == 0) ? 26'h3FFFFFF : 26'($urandom);
            c_in_data = 6'($urandom);
            b_in_tag = 4'(cyc); c_in_tag = 4'(cyc);
         end else begin
            b_in_valid = 1'b0; c_in_valid = 1'b0;
         end
         @(negedge clk);
         if (b_in_valid && b_in_ready) bq.push_back(ref_mod(longint'(b_in_data), 7681));
         if (c_in_valid && c_in_ready) cq.push_back(ref_mod(longint'(c_in_data), 5));
         if (b_out_valid) begin
            checks++;
            e = (bq.size() != 0) ? bq.pop_front() : -1;
            if (b_out_data !== 13'(e) || e < 0) begin
               failures++; $display("FAIL q7681 n=%0d got=%0d exp=%0d", bgot, b_out_data, e);
            end
            bgot++;
         end
         if (c_out_valid) begin
            checks++;
            e = (cq.size() != 0) ? cq.pop_front() : -1;
            if (c_out_data !== 3'(e) || e < 0) begin
               failures++; $display("FAIL q5 n=%0d got=%0d exp=%0d", cgot, c_out_data, e);
            end
            cgot++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bgot != 10000 || cgot != 10000) begin
         failures++; $display("FAIL param_count got=%0d/%0d exp=10000/10000", bgot, cgot);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_param();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/barrett_reduce_pipe.md
# barrett_reduce_pipe

Parametrised, pipelined Barrett modular reducer. It reduces a 2K-bit operand, typically a product of two residues, modulo a compile-time modulus Q. The result is fully reduced into [0, Q) for every input. A valid/ready stream interface with backpressure and a side-band tag lets several channels share one instance. It sits behind the modular multipliers in the Galois datapath and is the multi-modulus, streaming successor of the fixed Q = 3347 combinational reducer.

## Interface
- Q, default 3347: modulus, 3 ≤ Q; need not be prime.
- TAG_W, default 4: width of the pass-through channel/ID tag, ≥ 1.
- Derived localparams, not overridable:
  - K = $clog2(Q), 12 at the default.
  - MU = floor(2^(2K) / Q), 5012 at the default.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  2K  operand a; any value in [0, 2^(2K)).
- in_tag  in  TAG_W  tag travelling with the beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  K  a mod Q.
- out_tag  out  TAG_W  tag of the beat, unchanged.

## Operation
- Three register stages: S1, S2, S3. Each stage holds a valid bit, the tag and its data.
- Global enable: en = !out_valid || out_ready. in_ready = en. A beat is accepted when in_valid && in_ready. All stages shift together when en = 1 and hold when en = 0.
- S1 captures a and qh = (a >> K) * MU, carried at 2K+1 bits.
- S2 computes t = qh >> K and r = a − t*Q, carried at K+2 bits.
  - Guaranteed 0 ≤ r < 4Q.
  - Must not truncate below K+2 bits.
- S3 performs up to three conditional subtractions:
  - r ≥ 3Q → r − 3Q.
  - else r ≥ 2Q → r − 2Q.
  - else r ≥ Q → r − Q.
  - else r.
  - The low K bits of the result go to out_data.
- Bubbles (stage valid = 0) propagate like data. Only the valid bits are significant for empty stages; their data registers may hold stale values.
- Tags and data never reorder. Each out_tag is paired with the out_data computed from the same in_data.
- No state machine beyond the valid pipeline. Throughput is one beat per cycle while out_ready = 1.

## Timing
- Reset (rst_n low, asynchronous):
  - All stage valid bits, out_valid, out_data and out_tag = 0.
  - in_ready = 1 one combinational delay after reset assertion.
- Reset mid-operation drops all in-flight beats. Nothing is emitted after rst_n rises until new beats are accepted.
- Latency: a beat accepted at rising edge n appears on out_valid/out_data after edge n+3, provided en = 1 at edges n+1 and n+2.
- A stall (out_ready = 0 while out_valid = 1) freezes all stages. out_data and out_tag must stay stable until the beat is accepted. in_ready = 0 combinationally during the stall.
- Simultaneous accept-in and accept-out in the same cycle is legal; full throughput with no bubble insertion.
- in_valid = 0 while in_ready = 1 inserts a bubble. out_valid drops exactly 3 enabled cycles later.
- Combinational path from out_ready to in_ready is allowed and required. There is no other input-to-output combinational path.

## Test plan
- Reset, then stream a = 0, 3346, 3347 with tags 1, 2, 3 and out_ready = 1 → outputs 0, 3346, 0 with tags 1, 2, 3. The first out_valid occurs 3 cycles after the first accept; outputs arrive on consecutive cycles.
- a = 11195716 (3346²) → out_data = 1.
- a = 16777215 (2^24 − 1) → out_data = 2051. Here r = 8745 at S2, so the two-subtraction path must be taken; a single-subtract design gives 5398 and fails.
- Backpressure: stream 8 random beats while toggling out_ready with pattern 1,0,0,1,0,1,1,0,…
  - Outputs match the golden a mod 3347 in order with correct tags.
  - out_data and out_tag are held stable while out_ready = 0.
  - in_ready mirrors en.
- Assert rst_n low with 3 beats in flight → out_valid = 0 immediately, no stale beat after release. The next beat a = 6694 yields 0 after 3 cycles.
- Re-parametrise Q = 7681 (K = 13, MU = 8736) and Q = 5 (K = 3, MU = 12). Run 10,000 random a in [0, 2^(2K)) against a software mod model; zero mismatches.
